// File: rtl/load_buffer_pkg.sv
// Shared widths, load opcodes and entry layout
// for the in-order load buffer.
package load_buffer_pkg;

  localparam int InstTypeWidth = 6;
  localparam int ROBWidth      = 5;
  localparam int IDWidth       = 32;
  localparam int AddressWidth  = 32;
  localparam int LBCount       = 8;
  localparam int LBWidth       = 3;

  localparam logic [InstTypeWidth-1:0] LB  = 6'd11;
  localparam logic [InstTypeWidth-1:0] LH  = 6'd12;
  localparam logic [InstTypeWidth-1:0] LW  = 6'd13;
  localparam logic [InstTypeWidth-1:0] LBU = 6'd14;
  localparam logic [InstTypeWidth-1:0] LHU = 6'd15;

  typedef enum logic {
    IDLE,
    BUSY
  } lb_state_e;

  typedef struct packed {
    logic                     valid;
    logic [InstTypeWidth-1:0] op;
    logic [ROBWidth-1:0]      tag;
    logic [AddressWidth-1:0]  addr;
    logic                     addr_valid;
  } lb_entry_t;

endpackage

// File: rtl/load_extend.sv
// Maps a load opcode and right-aligned raw data
// to the extended result and access width code.
module load_extend
  import load_buffer_pkg::*;
(
  input  logic [InstTypeWidth-1:0] op_in,
  input  logic [IDWidth-1:0]       data_in,
  output logic [IDWidth-1:0]       result_out,
  output logic [2:0]               width_out
);

  // Sign/zero extension per opcode; unknown codes pass through as a word
  always_comb begin
    result_out = data_in;
    width_out  = 3'b100;
    case (op_in)
      LB: begin
        result_out = {{(IDWidth-8){data_in[7]}}, data_in[7:0]};
        width_out  = 3'b001;
      end
      LBU: begin
        result_out = {{(IDWidth-8){1'b0}}, data_in[7:0]};
        width_out  = 3'b001;
      end
      LH: begin
        result_out = {{(IDWidth-16){data_in[15]}}, data_in[15:0]};
        width_out  = 3'b010;
      end
      LHU: begin
        result_out = {{(IDWidth-16){1'b0}}, data_in[15:0]};
        width_out  = 3'b010;
      end
      default: begin
        result_out = data_in;
        width_out  = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/load_buffer.sv
// In-order load queue: captures addresses, checks store
// aliasing at the head, forwards or reads, writes back.
module load_buffer
  import load_buffer_pkg::*;
(
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     rob_rst_in,
  output logic                     lbuffer_rdy_out,
  input  logic                     dispatcher_lbuffer_en_in,
  input  logic [InstTypeWidth-1:0] dispatcher_lbuffer_opcode_in,
  input  logic [ROBWidth-1:0]      dispatcher_lbuffer_h_in,
  input  logic [ROBWidth-1:0]      addrunit_lbuffer_h_in,
  input  logic [AddressWidth-1:0]  addrunit_lbuffer_address_in,
  output logic [ROBWidth-1:0]      lbuffer_rob_index_out,
  input  logic                     rob_lbuffer_disambiguation_in,
  input  logic                     rob_lbuffer_forwarding_en_in,
  input  logic [IDWidth-1:0]       rob_lbuffer_forwarding_data_in,
  output logic                     lbuffer_datactrl_en_out,
  output logic [AddressWidth-1:0]  lbuffer_datactrl_addr_out,
  output logic [2:0]               lbuffer_datactrl_width_out,
  input  logic                     datactrl_lbuffer_en_in,
  input  logic [IDWidth-1:0]       datactrl_lbuffer_data_in,
  output logic [ROBWidth-1:0]      lbuffer_rob_h_out,
  output logic [IDWidth-1:0]       lbuffer_rob_result_out
);

  lb_entry_t                ent_q [LBCount];
  lb_entry_t                ent_d [LBCount];
  logic [LBWidth-1:0]       head_q, head_d;
  logic [LBWidth-1:0]       tail_q, tail_d;
  logic [LBWidth:0]         count_q, count_d;
  lb_state_e                state_q, state_d;
  logic                     en_q, en_d;
  logic [AddressWidth-1:0]  raddr_q, raddr_d;
  logic [2:0]               width_q, width_d;
  logic [ROBWidth-1:0]      h_q, h_d;
  logic [IDWidth-1:0]       res_q, res_d;
  logic                     pop, alloc;

  lb_entry_t                hd;
  logic                     head_ok;
  logic [IDWidth-1:0]       fwd_res, mem_res;
  logic [2:0]               hd_width, mem_width;
  logic                     bc_hit;

  assign hd      = ent_q[head_q];
  assign head_ok = (count_q != '0) && hd.valid && hd.addr_valid;
  assign bc_hit  = (addrunit_lbuffer_h_in != '0) &&
                   (addrunit_lbuffer_h_in == dispatcher_lbuffer_h_in);

  assign lbuffer_rdy_out =
    count_q < (LBWidth+1)'(LBCount - 1);
  assign lbuffer_rob_index_out      = head_ok ? hd.tag : '0;
  assign lbuffer_datactrl_en_out    = en_q;
  assign lbuffer_datactrl_addr_out  = raddr_q;
  assign lbuffer_datactrl_width_out = width_q;
  assign lbuffer_rob_h_out          = h_q;
  assign lbuffer_rob_result_out     = res_q;

  load_extend u_ext_fwd (
    .op_in      (hd.op),
    .data_in    (rob_lbuffer_forwarding_data_in),
    .result_out (fwd_res),
    .width_out  (hd_width)
  );

  load_extend u_ext_mem (
    .op_in      (hd.op),
    .data_in    (datactrl_lbuffer_data_in),
    .result_out (mem_res),
    .width_out  (mem_width)
  );

  // Next-state: flush, address capture, head decision, pop and allocate
  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    state_d = state_q;
    en_d    = en_q;
    raddr_d = raddr_q;
    width_d = width_q;
    h_d     = '0;
    res_d   = res_q;
    pop     = 1'b0;
    alloc   = 1'b0;
    if (rdy_in && rob_rst_in) begin
      for (int i = 0; i < LBCount; i++) ent_d[i] = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      state_d = IDLE;
      en_d    = 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < LBCount; i++) begin
        if (ent_q[i].valid && addrunit_lbuffer_h_in != '0 &&
            ent_q[i].tag == addrunit_lbuffer_h_in) begin
          ent_d[i].addr       = addrunit_lbuffer_address_in;
          ent_d[i].addr_valid = 1'b1;
        end
      end
      unique case (state_q)
        IDLE: begin
          if (head_ok) begin
            if (rob_lbuffer_forwarding_en_in) begin
              h_d   = hd.tag;
              res_d = fwd_res;
              pop   = 1'b1;
            end else if (rob_lbuffer_disambiguation_in) begin
              en_d    = 1'b1;
              raddr_d = hd.addr;
              width_d = hd_width;
              state_d = BUSY;
            end
          end
        end
        BUSY: begin
          if (datactrl_lbuffer_en_in) begin
            en_d    = 1'b0;
            h_d     = hd.tag;
            res_d   = mem_res;
            pop     = 1'b1;
            state_d = IDLE;
          end
        end
      endcase
      if (pop) begin
        ent_d[head_q].valid      = 1'b0;
        ent_d[head_q].addr_valid = 1'b0;
        head_d = head_q + LBWidth'(1);
      end
      if (dispatcher_lbuffer_en_in) begin
        alloc = 1'b1;
        ent_d[tail_q].valid      = 1'b1;
        ent_d[tail_q].op         = dispatcher_lbuffer_opcode_in;
        ent_d[tail_q].tag        = dispatcher_lbuffer_h_in;
        ent_d[tail_q].addr       = addrunit_lbuffer_address_in;
        ent_d[tail_q].addr_valid = bc_hit;
        tail_d = tail_q + LBWidth'(1);
      end
      count_d = count_q + (LBWidth+1)'(alloc)
                        - (LBWidth+1)'(pop);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < LBCount; i++) ent_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= IDLE;
      en_q    <= 1'b0;
      raddr_q <= '0;
      width_q <= '0;
      h_q     <= '0;
      res_q   <= '0;
    end else begin
      for (int i = 0; i < LBCount; i++) ent_q[i] <= ent_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      en_q    <= en_d;
      raddr_q <= raddr_d;
      width_q <= width_d;
      h_q     <= h_d;
      res_q   <= res_d;
    end
  end

  // Dispatch into a full buffer would overwrite the head
  a_no_overflow : assert property (
    @(posedge clk_in) disable iff (rst_in)
    !(rdy_in && !rob_rst_in && dispatcher_lbuffer_en_in &&
      count_q == (LBWidth+1)'(LBCount)));

endmodule

// File: tb/tb_load_buffer.sv
// Self-checking bench for load_buffer: vector table
// plus aliasing, fill/wrap, flush and same-cycle cases.
module tb_load_buffer;
  import load_buffer_pkg::*;

  logic clk;
  logic rst, rdy, rob_rst;
  logic rdy_out;
  logic disp_en;
  logic [InstTypeWidth-1:0] disp_op;
  logic [ROBWidth-1:0] disp_h;
  logic [ROBWidth-1:0] au_h;
  logic [AddressWidth-1:0] au_addr;
  logic [ROBWidth-1:0] idx;
  logic disamb, fwd_en;
  logic [IDWidth-1:0] fwd_data;
  logic dc_req;
  logic [AddressWidth-1:0] dc_addr;
  logic [2:0] dc_width;
  logic dc_done;
  logic [IDWidth-1:0] dc_data;
  logic [ROBWidth-1:0] h_out;
  logic [IDWidth-1:0] result;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [InstTypeWidth-1:0] op;
    logic [ROBWidth-1:0] tag;
    logic [31:0] addr;
    logic [31:0] mem;
    logic [31:0] exp;
    logic [2:0] wid;
  } vec_t;

  typedef struct {
    logic [ROBWidth-1:0] tag;
    logic [31:0] res;
  } exp_t;

  vec_t vecs[6];
  exp_t sbq[$];
  exp_t mon_e;

  load_buffer dut (
    .clk_in                         (clk),
    .rst_in                         (rst),
    .rdy_in                         (rdy),
    .rob_rst_in                     (rob_rst),
    .lbuffer_rdy_out                (rdy_out),
    .dispatcher_lbuffer_en_in       (disp_en),
    .dispatcher_lbuffer_opcode_in   (disp_op),
    .dispatcher_lbuffer_h_in        (disp_h),
    .addrunit_lbuffer_h_in          (au_h),
    .addrunit_lbuffer_address_in    (au_addr),
    .lbuffer_rob_index_out          (idx),
    .rob_lbuffer_disambiguation_in  (disamb),
    .rob_lbuffer_forwarding_en_in   (fwd_en),
    .rob_lbuffer_forwarding_data_in (fwd_data),
    .lbuffer_datactrl_en_out        (dc_req),
    .lbuffer_datactrl_addr_out      (dc_addr),
    .lbuffer_datactrl_width_out     (dc_width),
    .datactrl_lbuffer_en_in         (dc_done),
    .datactrl_lbuffer_data_in       (dc_data),
    .lbuffer_rob_h_out              (h_out),
    .lbuffer_rob_result_out         (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int lim);
    int n = 0;
    while (!dc_req && n < lim) begin
      tick();
      n++;
    end
    checks++;
    if (!dc_req) begin
      failures++;
      $display("FAIL req_timeout got=0 want=1");
    end
  endtask

  // Result monitor: every pulse must match the scoreboard head
  always @(posedge clk) begin
    #2;
    if (h_out !== '0) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result tag=%0d want=none",
                 h_out);
      end else begin
        mon_e = sbq.pop_front();
        chk("result_tag", 32'(h_out), 32'(mon_e.tag));
        chk("result_data", result, mon_e.res);
      end
    end
  end

  initial begin
    vecs[0] = '{LW,  5'd3, 32'h100, 32'hDEADBEEF,
                32'hDEADBEEF, 3'b100};
    vecs[1] = '{LB,  5'd4, 32'h104, 32'h00000080,
                32'hFFFFFF80, 3'b001};
    vecs[2] = '{LBU, 5'd6, 32'h104, 32'h00000080,
                32'h00000080, 3'b001};
    vecs[3] = '{LH,  5'd7, 32'h108, 32'h00008001,
                32'hFFFF8001, 3'b010};
    vecs[4] = '{LHU, 5'd8, 32'h10A, 32'h00008001,
                32'h00008001, 3'b010};
    vecs[5] = '{LB,  5'd9, 32'h10C, 32'h1234567F,
                32'h0000007F, 3'b001};

    rst = 1'b1; rdy = 1'b1; rob_rst = 1'b0;
    disp_en = 1'b0; disp_op = LW; disp_h = '0;
    au_h = '0; au_addr = '0;
    disamb = 1'b0; fwd_en = 1'b0; fwd_data = '0;
    dc_done = 1'b0; dc_data = '0;
    tick();
    tick();
    chk("rst_rdy", 32'(rdy_out), 32'd1);
    chk("rst_req", 32'(dc_req), 32'd0);
    chk("rst_h", 32'(h_out), 32'd0);
    chk("rst_idx", 32'(idx), 32'd0);
    rst = 1'b0;

    disamb = 1'b1;
    for (int v = 0; v < 6; v++) begin
      disp_en = 1'b1;
      disp_op = vecs[v].op;
      disp_h  = vecs[v].tag;
      tick();
      disp_en = 1'b0;
      au_h    = vecs[v].tag;
      au_addr = vecs[v].addr;
      tick();
      au_h = '0;
      chk("vec_idx", 32'(idx), 32'(vecs[v].tag));
      wait_req(5);
      for (int c = 0; c < 3; c++) begin
        chk("vec_addr", dc_addr, vecs[v].addr);
        chk("vec_width", 32'(dc_width), 32'(vecs[v].wid));
        tick();
      end
      chk("vec_hold", 32'(dc_req), 32'd1);
      dc_done = 1'b1;
      dc_data = vecs[v].mem;
      sbq.push_back('{vecs[v].tag, vecs[v].exp});
      tick();
      dc_done = 1'b0;
      chk("vec_req_drop", 32'(dc_req), 32'd0);
      tick();
      chk("vec_pulse_once", 32'(h_out), 32'd0);
    end

    disamb = 1'b0;
    disp_en = 1'b1; disp_op = LHU; disp_h = 5'd10;
    tick();
    disp_en = 1'b0;
    au_h = 5'd10; au_addr = 32'h200;
    tick();
    au_h = '0;
    chk("alias_idx", 32'(idx), 32'd10);
    for (int c = 0; c < 5; c++) begin
      chk("alias_stall", 32'(dc_req), 32'd0);
      tick();
    end
    fwd_en = 1'b1; fwd_data = 32'h12345678;
    sbq.push_back('{5'd10, 32'h00005678});
    tick();
    fwd_en = 1'b0;
    chk("alias_no_req", 32'(dc_req), 32'd0);
    chk("alias_empty_idx", 32'(idx), 32'd0);

    disp_op = LW;
    for (int i = 0; i < 7; i++) begin
      disp_en = 1'b1;
      disp_h  = 5'(11 + i);
      tick();
      chk("fill_rdy", 32'(rdy_out), (i + 1 < 7) ? 32'd1 : 32'd0);
    end
    disp_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      au_h    = 5'(11 + i);
      au_addr = 32'h400 + 32'(i * 4);
      tick();
    end
    au_h = '0;
    chk("fill_head", 32'(idx), 32'd11);
    fwd_en = 1'b1; fwd_data = 32'h11;
    sbq.push_back('{5'd11, 32'h11});
    disp_en = 1'b1; disp_h = 5'd18;
    tick();
    disp_en = 1'b0; fwd_en = 1'b0;
    chk("swap_rdy", 32'(rdy_out), 32'd0);
    chk("swap_head", 32'(idx), 32'd12);
    au_h = 5'd18; au_addr = 32'h41C;
    tick();
    au_h = '0;
    fwd_en = 1'b1;
    for (int t = 12; t <= 18; t++) begin
      fwd_data = 32'(t * 32'h1111);
      sbq.push_back('{5'(t), 32'(t * 32'h1111)});
      tick();
    end
    fwd_en = 1'b0;
    chk("drain_rdy", 32'(rdy_out), 32'd1);
    chk("drain_idx", 32'(idx), 32'd0);

    disamb = 1'b1;
    disp_en = 1'b1; disp_op = LW; disp_h = 5'd20;
    tick();
    disp_en = 1'b0;
    au_h = 5'd20; au_addr = 32'h500;
    tick();
    au_h = '0;
    wait_req(5);
    rob_rst = 1'b1; dc_done = 1'b1; dc_data = 32'hAAAA5555;
    tick();
    rob_rst = 1'b0; dc_done = 1'b0;
    chk("flush_req", 32'(dc_req), 32'd0);
    chk("flush_rdy", 32'(rdy_out), 32'd1);
    chk("flush_idx", 32'(idx), 32'd0);

    disp_en = 1'b1; disp_op = LBU; disp_h = 5'd5;
    au_h = 5'd5; au_addr = 32'h600;
    tick();
    disp_en = 1'b0; au_h = '0;
    chk("same_cyc_idx", 32'(idx), 32'd5);
    wait_req(5);
    chk("same_cyc_addr", dc_addr, 32'h600);
    chk("same_cyc_width", 32'(dc_width), 32'b001);
    dc_done = 1'b1; dc_data = 32'h000000FF;
    sbq.push_back('{5'd5, 32'h000000FF});
    tick();
    dc_done = 1'b0;
    tick();
    tick();
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
